skullfet_cell_tester: RTL and testbench

//   Self-test sequencer for the hand-drawn skullfet_inverter and skullfet_nand cells.

---
 rtl/skullfet_cell_tester.sv | 142 ++++++++++++++
 tb/tb_skullfet_cell_tester.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/skullfet_cell_tester.sv
// Self-test sequencer for the skullfet inverter and nand cells: drives four
// input vectors, samples the synchronised outputs and accumulates error stats.
module skullfet_cell_tester #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             loop_en,
  output logic             inv_a,
  output logic             nand_a,
  output logic             nand_b,
  input  logic             inv_y,
  input  logic             nand_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_mask,
  output logic [1:0]       vector_idx
);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_t;

  localparam logic [ERR_W:0] ERR_MAX  = {1'b0, {ERR_W{1'b1}}};
  localparam logic [7:0]     SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t state, state_nxt;

  logic [7:0]             settle_cnt;
  logic [SYNC_STAGES-1:0] inv_sync, nand_sync;
  logic                   inv_s, nand_s;
  logic                   inv_bad, nand_bad;
  logic [ERR_W:0]         err_sum;
  logic [ERR_W-1:0]       err_next;
  logic [7:0]             mask_hit;
  logic [1:0]             idx_inc;

  // Cell outputs are asynchronous to clk, so each passes through a flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_sync  <= '0;
      nand_sync <= '0;
    end else begin
      inv_sync  <= {inv_sync[SYNC_STAGES-2:0], inv_y};
      nand_sync <= {nand_sync[SYNC_STAGES-2:0], nand_y};
    end
  end

  assign inv_s  = inv_sync[SYNC_STAGES-1];
  assign nand_s = nand_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (vector_idx == 2'd3) ? FINISH : DRIVE;
      FINISH:  state_nxt = loop_en ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Expected values come from the drive registers, which hold the current
  // vector until the edge leaving SAMPLE.
  always_comb begin
    inv_bad  = (inv_s != ~inv_a);
    nand_bad = (nand_s != ~(nand_a & nand_b));
    err_sum  = {1'b0, err_count} + (ERR_W+1)'(inv_bad) + (ERR_W+1)'(nand_bad);
    err_next = (err_sum > ERR_MAX) ? ERR_MAX[ERR_W-1:0] : err_sum[ERR_W-1:0];
    mask_hit = '0;
    mask_hit[{1'b0, vector_idx}] = inv_bad;
    mask_hit[{1'b1, vector_idx}] = nand_bad;
    idx_inc  = vector_idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_a      <= 1'b0;
      nand_a     <= 1'b0;
      nand_b     <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_mask  <= '0;
      vector_idx <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vector_idx <= '0;
            err_count  <= '0;
            fail_mask  <= '0;
            inv_a      <= 1'b0;
            nand_a     <= 1'b0;
            nand_b     <= 1'b0;
          end
        end
        DRIVE:  settle_cnt <= '0;
        SETTLE: settle_cnt <= settle_cnt + 8'd1;
        SAMPLE: begin
          err_count <= err_next;
          fail_mask <= fail_mask | mask_hit;
          if (vector_idx != 2'd3) begin
            vector_idx <= idx_inc;
            nand_a     <= idx_inc[1];
            nand_b     <= idx_inc[0];
            inv_a      <= idx_inc[0];
          end
        end
        FINISH: begin
          pass <= (fail_mask == 8'h00);
          if (loop_en) begin
            vector_idx <= '0;
            inv_a      <= 1'b0;
            nand_a     <= 1'b0;
            nand_b     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == DRIVE) || (state == SETTLE) || (state == SAMPLE);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_skullfet_cell_tester.sv
// Directed bench for skullfet_cell_tester using behavioural cell models with
// injectable faults (inverter acting as buffer, nand output stuck at 0).
module tb_skullfet_cell_tester;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic       inv_a, nand_a, nand_b;
  logic       inv_y, nand_y;
  logic       busy, done, pass;
  logic [7:0] err_count, fail_mask;
  logic [1:0] vector_idx;

  logic invFault = 1'b0;
  logic nandStuck = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc;
  int doneCount;

  assign inv_y  = invFault ? inv_a : ~inv_a;
  assign nand_y = nandStuck ? 1'b0 : ~(nand_a & nand_b);

  always #5 clk = ~clk;

  skullfet_cell_tester dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .loop_en    (loop_en),
    .inv_a      (inv_a),
    .nand_a     (nand_a),
    .nand_b     (nand_b),
    .inv_y      (inv_y),
    .nand_y     (nand_y),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_mask  (fail_mask),
    .vector_idx (vector_idx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise start so the next posedge sees it; returns just after that edge.
  task automatic applyStimulus;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Advances at least one cycle, then returns the cycle number at which done was seen.
  task automatic waitDone(input int maxCycles, output int cycles);
    cycles = 0;
    for (int k = 1; k <= maxCycles; k++) begin
      @(negedge clk);
      if (done) begin
        cycles = k;
        break;
      end
    end
    checkOutput("doneSeen", (cycles != 0), 1);
  endtask

  task automatic checkDrive(input string tag, input logic [1:0] idx, input logic [2:0] abi);
    checkOutput({tag, "_idx"}, vector_idx, idx);
    checkOutput({tag, "_drive"}, {nand_a, nand_b, inv_a}, abi);
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rstOuts", {inv_a, nand_a, nand_b, busy, done, pass}, 6'b0);
    checkOutput("rstErr", err_count, 0);
    checkOutput("rstMask", fail_mask, 0);
    checkOutput("rstIdx", vector_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Ideal cells
    applyStimulus();
    waitDone(60, cyc);
    checkOutput("t1Cycle", cyc, 41);
    checkOutput("t1Err", err_count, 0);
    checkOutput("t1Mask", fail_mask, 8'h00);
    @(negedge clk);
    checkOutput("t1Pass", pass, 1);
    checkOutput("t1Idle", {busy, done}, 2'b00);

    // nand stuck at 0, also walks the drive vectors
    nandStuck = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("t2Busy", busy, 1);
    checkDrive("t2v0", 2'd0, 3'b000);
    repeat (10) @(negedge clk);
    checkDrive("t2v1", 2'd1, 3'b011);
    repeat (10) @(negedge clk);
    checkDrive("t2v2", 2'd2, 3'b100);
    repeat (10) @(negedge clk);
    checkDrive("t2v3", 2'd3, 3'b111);
    waitDone(20, cyc);
    checkOutput("t2Cycle", cyc, 10);
    checkOutput("t2Err", err_count, 3);
    checkOutput("t2Mask", fail_mask, 8'h70);
    @(negedge clk);
    checkOutput("t2Pass", pass, 0);
    checkDrive("t2Hold", 2'd3, 3'b111);
    nandStuck = 1'b0;

    // Inverter acting as a buffer
    invFault = 1'b1;
    applyStimulus();
    waitDone(60, cyc);
    checkOutput("t3Err", err_count, 4);
    checkOutput("t3Mask", fail_mask, 8'h0F);
    @(negedge clk);
    checkOutput("t3Pass", pass, 0);

    // Looping with both faults until the counter saturates
    nandStuck = 1'b1;
    loop_en = 1'b1;
    applyStimulus();
    for (int r = 1; r <= 38; r++) begin
      waitDone(60, cyc);
      if (r == 1)  checkOutput("t4Run1", err_count, 7);
      if (r == 2)  checkOutput("t4LoopCycle", cyc, 41);
      if (r == 36) checkOutput("t4Run36", err_count, 252);
      if (r == 37) checkOutput("t4Run37", err_count, 255);
      if (r == 38) begin
        checkOutput("t4Hold", err_count, 255);
        checkOutput("t4Mask", fail_mask, 8'h7F);
        loop_en = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("t4Pass", pass, 0);
    checkOutput("t4Stop", {busy, done}, 2'b00);
    invFault = 1'b0;
    nandStuck = 1'b0;

    // Reset during SETTLE of vector 2
    applyStimulus();
    repeat (25) @(negedge clk);
    checkDrive("t5Pre", 2'd2, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5Outs", {inv_a, nand_a, nand_b, busy, done, pass}, 6'b0);
    checkOutput("t5Err", err_count, 0);
    checkOutput("t5Mask", fail_mask, 0);
    checkOutput("t5Idx", vector_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("t5NoDone", doneCount, 0);
    applyStimulus();
    waitDone(60, cyc);
    checkOutput("t5Cycle", cyc, 41);
    checkOutput("t5Err2", err_count, 0);
    @(negedge clk);
    checkOutput("t5Pass", pass, 1);

    // start re-pulsed while busy
    nandStuck = 1'b1;
    applyStimulus();
    repeat (25) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("t6ErrMid", err_count, 2);
    doneCount = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("t6OneDone", doneCount, 1);
    checkOutput("t6Err", err_count, 3);
    checkOutput("t6Mask", fail_mask, 8'h70);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
